// File: rtl/resp_router.sv
// Response router: tracks grant winners in an in-order FIFO and steers responses back to them.
// Optional sticky protocol checking is enabled with the macro RESP_ROUTER_ERR_CHECK_EN.
module resp_router #(
  parameter int NUM_REQUESTERS  = 4,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [NUM_REQUESTERS-1:0]          i_grants,
  input  logic                               i_issue_valid,
  output logic                               o_issue_ready,
  input  logic                               i_resp_valid,
  input  logic [DATA_WIDTH-1:0]              i_resp_data,
  output logic                               o_resp_ready,
  output logic [NUM_REQUESTERS-1:0]          o_resp_valid,
  output logic [DATA_WIDTH-1:0]              o_resp_data,
  input  logic [NUM_REQUESTERS-1:0]          i_resp_ready,
  output logic [$clog2(MAX_OUTSTANDING):0]   o_outstanding,
  output logic                               o_err
);

  localparam int PW = $clog2(MAX_OUTSTANDING);
  localparam int IW = $clog2(NUM_REQUESTERS);

  function automatic logic [IW-1:0] lowest_idx(input logic [NUM_REQUESTERS-1:0] g);
    lowest_idx = {IW{1'b0}};
    for (int i = NUM_REQUESTERS - 1; i >= 0; i--) begin
      if (g[i]) lowest_idx = IW'(i);
    end
  endfunction

  logic [IW-1:0] mem_r [MAX_OUTSTANDING];
  logic [PW:0]   wr_ptr_r, rd_ptr_r, count_r;
  logic [PW:0]   wr_nxt_s, rd_nxt_s;
  logic          empty_s, full_s, push_s, pop_s;
  logic [IW-1:0] head_idx_s;
  logic [NUM_REQUESTERS-1:0] resp_valid_s;

  assign empty_s    = (count_r == {(PW+1){1'b0}});
  assign full_s     = (count_r == (PW+1)'(MAX_OUTSTANDING));
  assign head_idx_s = mem_r[rd_ptr_r[PW-1:0]];

  assign o_issue_ready = !full_s;
  assign o_resp_ready  = !empty_s && i_resp_ready[head_idx_s];
  assign o_resp_data   = i_resp_data;
  assign o_resp_valid  = resp_valid_s;
  assign o_outstanding = count_r;

  assign push_s = i_issue_valid && !full_s && (i_grants != {NUM_REQUESTERS{1'b0}});
  assign pop_s  = i_resp_valid && o_resp_ready;

  // Next pointer values; the count register is derived from them so it tracks wr - rd exactly
  always_comb begin
    wr_nxt_s = wr_ptr_r;
    rd_nxt_s = rd_ptr_r;
    if (push_s) wr_nxt_s = wr_ptr_r + {{PW{1'b0}}, 1'b1};
    else        wr_nxt_s = wr_ptr_r;
    if (pop_s)  rd_nxt_s = rd_ptr_r + {{PW{1'b0}}, 1'b1};
    else        rd_nxt_s = rd_ptr_r;
  end

  // Steer the response valid to the requester recorded at the FIFO head
  always_comb begin
    resp_valid_s = {NUM_REQUESTERS{1'b0}};
    if (i_resp_valid && !empty_s) resp_valid_s[head_idx_s] = 1'b1;
    else                          resp_valid_s = {NUM_REQUESTERS{1'b0}};
  end

  // Tracking FIFO storage, pointers and registered occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {(PW+1){1'b0}};
      rd_ptr_r <= {(PW+1){1'b0}};
      count_r  <= {(PW+1){1'b0}};
      for (int i = 0; i < MAX_OUTSTANDING; i++) mem_r[i] <= {IW{1'b0}};
    end else begin
      if (push_s) mem_r[wr_ptr_r[PW-1:0]] <= lowest_idx(i_grants);
      wr_ptr_r <= wr_nxt_s;
      rd_ptr_r <= rd_nxt_s;
      count_r  <= wr_nxt_s - rd_nxt_s;
    end
  end

`ifdef RESP_ROUTER_ERR_CHECK_EN
  logic err_r, empty_resp_r, err_cond_s, onehot_s;

  assign onehot_s = (i_grants != {NUM_REQUESTERS{1'b0}}) &&
                    ((i_grants & (i_grants - {{(NUM_REQUESTERS-1){1'b0}}, 1'b1})) ==
                     {NUM_REQUESTERS{1'b0}});
  // A response valid is tolerated for one empty cycle; a second consecutive one is an error
  assign err_cond_s = (i_issue_valid && !onehot_s) ||
                      (i_issue_valid && full_s) ||
                      (i_resp_valid && empty_s && empty_resp_r);

  // Sticky error flag, cleared only by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_r        <= 1'b0;
      empty_resp_r <= 1'b0;
    end else begin
      empty_resp_r <= i_resp_valid && empty_s;
      if (err_cond_s) err_r <= 1'b1;
    end
  end

  assign o_err = err_r;
`else
  assign o_err = 1'b0;
`endif

endmodule

// File: tb/tb_resp_router.sv
// Self-checking bench for resp_router: scoreboard of expected requester indices per issue.
module tb_resp_router;

`ifdef RESP_ROUTER_ERR_CHECK_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  i_grants = 4'b0000;
  logic        i_issue_valid = 1'b0;
  logic        o_issue_ready;
  logic        i_resp_valid = 1'b0;
  logic [31:0] i_resp_data = 32'h0;
  logic        o_resp_ready;
  logic [3:0]  o_resp_valid;
  logic [31:0] o_resp_data;
  logic [3:0]  i_resp_ready = 4'b0000;
  logic [3:0]  o_outstanding;
  logic        o_err;

  int checks = 0;
  int errors = 0;
  int exp_q[$];

  resp_router dut (
    .clk(clk), .rst_n(rst_n), .i_grants(i_grants), .i_issue_valid(i_issue_valid),
    .o_issue_ready(o_issue_ready), .i_resp_valid(i_resp_valid), .i_resp_data(i_resp_data),
    .o_resp_ready(o_resp_ready), .o_resp_valid(o_resp_valid), .o_resp_data(o_resp_data),
    .i_resp_ready(i_resp_ready), .o_outstanding(o_outstanding), .o_err(o_err)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic [3:0] g, input logic iv, input logic rv,
                       input logic [31:0] d, input logic [3:0] rr);
    @(negedge clk);
    i_grants = g; i_issue_valid = iv; i_resp_valid = rv; i_resp_data = d; i_resp_ready = rr;
    #1;
  endtask

  task automatic idle();
    drive(4'b0000, 1'b0, 1'b0, 32'h0, 4'b0000);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    i_grants = 4'b0000; i_issue_valid = 1'b0; i_resp_valid = 1'b0; i_resp_ready = 4'b0000;
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
  endtask

  task automatic test_reset();
    idle();
    checks++; if (o_issue_ready !== 1'b1) begin errors++; $display("FAIL reset_issue_ready got %b exp 1", o_issue_ready); end
    checks++; if (o_resp_valid !== 4'b0000) begin errors++; $display("FAIL reset_resp_valid got %b exp 0000", o_resp_valid); end
    checks++; if (o_resp_ready !== 1'b0) begin errors++; $display("FAIL reset_resp_ready got %b exp 0", o_resp_ready); end
    checks++; if (o_outstanding !== 4'd0) begin errors++; $display("FAIL reset_outstanding got %0d exp 0", o_outstanding); end
    checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", o_err); end
    @(negedge clk); rst_n = 1'b1;
    idle();
    checks++; if (o_outstanding !== 4'd0) begin errors++; $display("FAIL post_reset_outstanding got %0d exp 0", o_outstanding); end
  endtask

  task automatic test_in_order();
    logic [3:0] g [3];
    logic [31:0] d [3];
    logic [3:0] e;
    int cnt;
    g[0] = 4'b0001; g[1] = 4'b0100; g[2] = 4'b0010;
    d[0] = 32'hD000_0000; d[1] = 32'hD111_1111; d[2] = 32'hD222_2222;
    exp_q.push_back(0); exp_q.push_back(2); exp_q.push_back(1);
    for (int i = 0; i < 3; i++) begin
      drive(g[i], 1'b1, 1'b0, 32'h0, 4'b0000);
      checks++; if (o_issue_ready !== 1'b1) begin errors++; $display("FAIL inorder_issue_ready got %b exp 1", o_issue_ready); end
    end
    cnt = 3;
    for (int i = 0; i < 3; i++) begin
      drive(4'b0000, 1'b0, 1'b1, d[i], 4'b1111);
      e = 4'b0001 << exp_q.pop_front();
      checks++; if (o_outstanding !== 4'(cnt)) begin errors++; $display("FAIL inorder_outstanding got %0d exp %0d", o_outstanding, cnt); end
      checks++; if (o_resp_valid !== e) begin errors++; $display("FAIL inorder_valid got %b exp %b", o_resp_valid, e); end
      checks++; if (o_resp_data !== d[i]) begin errors++; $display("FAIL inorder_data got %h exp %h", o_resp_data, d[i]); end
      checks++; if (o_resp_ready !== 1'b1) begin errors++; $display("FAIL inorder_ready got %b exp 1", o_resp_ready); end
      cnt--;
    end
    idle();
    checks++; if (o_outstanding !== 4'd0) begin errors++; $display("FAIL inorder_drain got %0d exp 0", o_outstanding); end
  endtask

  task automatic test_earliest();
    drive(4'b0100, 1'b1, 1'b1, 32'hE0, 4'b1111);
    checks++; if (o_resp_ready !== 1'b0) begin errors++; $display("FAIL same_cycle_ready got %b exp 0", o_resp_ready); end
    checks++; if (o_resp_valid !== 4'b0000) begin errors++; $display("FAIL same_cycle_valid got %b exp 0000", o_resp_valid); end
    exp_q.push_back(2);
    drive(4'b0000, 1'b0, 1'b1, 32'hE0, 4'b1111);
    checks++; if (o_resp_valid !== (4'b0001 << exp_q[0])) begin errors++; $display("FAIL earliest_valid got %b exp 0100", o_resp_valid); end
    checks++; if (o_resp_ready !== 1'b1) begin errors++; $display("FAIL earliest_ready got %b exp 1", o_resp_ready); end
    void'(exp_q.pop_front());
    idle();
    checks++; if (o_outstanding !== 4'd0) begin errors++; $display("FAIL earliest_drain got %0d exp 0", o_outstanding); end
  endtask

  task automatic test_fill();
    int r;
    logic [3:0] e;
    for (int i = 0; i < 8; i++) begin
      r = $urandom_range(0, 3);
      drive(4'b0001 << r, 1'b1, 1'b0, 32'h0, 4'b0000);
      checks++; if (o_issue_ready !== 1'b1) begin errors++; $display("FAIL fill_ready_before got %b exp 1 at %0d", o_issue_ready, i); end
      exp_q.push_back(r);
    end
    idle();
    checks++; if (o_issue_ready !== 1'b0) begin errors++; $display("FAIL fill_full_ready got %b exp 0", o_issue_ready); end
    checks++; if (o_outstanding !== 4'd8) begin errors++; $display("FAIL fill_outstanding got %0d exp 8", o_outstanding); end
    for (int i = 0; i < 8; i++) begin
      drive(4'b0000, 1'b0, 1'b1, 32'hF000 + 32'(i), 4'b1111);
      e = 4'b0001 << exp_q.pop_front();
      checks++; if (o_resp_valid !== e) begin errors++; $display("FAIL fill_valid got %b exp %b", o_resp_valid, e); end
      checks++; if (o_resp_ready !== 1'b1) begin errors++; $display("FAIL fill_pop_ready got %b exp 1", o_resp_ready); end
      if (i == 0) begin
        checks++; if (o_issue_ready !== 1'b0) begin errors++; $display("FAIL fill_no_bypass got %b exp 0", o_issue_ready); end
        idle();
        checks++; if (o_issue_ready !== 1'b1) begin errors++; $display("FAIL fill_ready_after_pop got %b exp 1", o_issue_ready); end
        checks++; if (o_outstanding !== 4'd7) begin errors++; $display("FAIL fill_after_pop got %0d exp 7", o_outstanding); end
      end
    end
    idle();
    checks++; if (o_outstanding !== 4'd0) begin errors++; $display("FAIL fill_drain got %0d exp 0", o_outstanding); end
  endtask

  task automatic test_backpressure();
    drive(4'b1000, 1'b1, 1'b0, 32'h0, 4'b0000);
    for (int i = 0; i < 3; i++) begin
      drive(4'b0000, 1'b0, 1'b1, 32'hBEEF, 4'b0111);
      checks++; if (o_resp_valid !== 4'b1000) begin errors++; $display("FAIL bp_valid got %b exp 1000", o_resp_valid); end
      checks++; if (o_resp_ready !== 1'b0) begin errors++; $display("FAIL bp_ready got %b exp 0", o_resp_ready); end
      checks++; if (o_outstanding !== 4'd1) begin errors++; $display("FAIL bp_outstanding got %0d exp 1", o_outstanding); end
    end
    drive(4'b0000, 1'b0, 1'b1, 32'hBEEF, 4'b1111);
    checks++; if (o_resp_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready got %b exp 1", o_resp_ready); end
    idle();
    checks++; if (o_outstanding !== 4'd0) begin errors++; $display("FAIL bp_drain got %0d exp 0", o_outstanding); end
  endtask

  task automatic test_back_to_back();
    int r;
    logic [3:0] e;
    for (int i = 0; i < 2; i++) begin
      r = $urandom_range(0, 3);
      drive(4'b0001 << r, 1'b1, 1'b0, 32'h0, 4'b0000);
      exp_q.push_back(r);
    end
    for (int i = 0; i < 20; i++) begin
      r = $urandom_range(0, 3);
      drive(4'b0001 << r, 1'b1, 1'b1, 32'hA00 + 32'(i), 4'b1111);
      e = 4'b0001 << exp_q.pop_front();
      exp_q.push_back(r);
      checks++; if (o_outstanding !== 4'd2) begin errors++; $display("FAIL b2b_outstanding got %0d exp 2 at %0d", o_outstanding, i); end
      checks++; if (o_resp_valid !== e) begin errors++; $display("FAIL b2b_valid got %b exp %b at %0d", o_resp_valid, e, i); end
      checks++; if (o_resp_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready got %b exp 1 at %0d", o_resp_ready, i); end
    end
    for (int i = 0; i < 2; i++) begin
      drive(4'b0000, 1'b0, 1'b1, 32'h0, 4'b1111);
      e = 4'b0001 << exp_q.pop_front();
      checks++; if (o_resp_valid !== e) begin errors++; $display("FAIL b2b_drain_valid got %b exp %b", o_resp_valid, e); end
    end
    idle();
    checks++; if (o_outstanding !== 4'd0) begin errors++; $display("FAIL b2b_drain got %0d exp 0", o_outstanding); end
    checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL clean_err got %b exp 0", o_err); end
  endtask

  task automatic test_empty_resp();
    logic exp_err;
    for (int c = 1; c <= 4; c++) begin
      drive(4'b0000, 1'b0, 1'b1, 32'h5A5A, 4'b1111);
      exp_err = ERR_EN && (c >= 3);
      checks++; if (o_resp_ready !== 1'b0) begin errors++; $display("FAIL empty_ready got %b exp 0", o_resp_ready); end
      checks++; if (o_resp_valid !== 4'b0000) begin errors++; $display("FAIL empty_valid got %b exp 0000", o_resp_valid); end
      checks++; if (o_err !== exp_err) begin errors++; $display("FAIL empty_err got %b exp %b cycle %0d", o_err, exp_err, c); end
    end
    idle();
    checks++; if (o_outstanding !== 4'd0) begin errors++; $display("FAIL empty_outstanding got %0d exp 0", o_outstanding); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) drive(4'b0010, 1'b1, 1'b0, 32'h0, 4'b0000);
    drive(4'b0000, 1'b0, 1'b1, 32'h1234, 4'b0000);
    checks++; if (o_resp_valid !== 4'b0010) begin errors++; $display("FAIL mid_valid got %b exp 0010", o_resp_valid); end
    checks++; if (o_outstanding !== 4'd5) begin errors++; $display("FAIL mid_outstanding got %0d exp 5", o_outstanding); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (o_outstanding !== 4'd0) begin errors++; $display("FAIL mid_rst_outstanding got %0d exp 0", o_outstanding); end
    checks++; if (o_issue_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_issue_ready got %b exp 1", o_issue_ready); end
    checks++; if (o_resp_valid !== 4'b0000) begin errors++; $display("FAIL mid_rst_valid got %b exp 0000", o_resp_valid); end
    checks++; if (o_resp_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_ready got %b exp 0", o_resp_ready); end
    checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL mid_rst_err got %b exp 0", o_err); end
    @(negedge clk);
    i_resp_valid = 1'b0; i_resp_ready = 4'b0000;
    rst_n = 1'b1;
    exp_q.delete();
    drive(4'b0000, 1'b0, 1'b1, 32'h1234, 4'b1111);
    checks++; if (o_resp_ready !== 1'b0) begin errors++; $display("FAIL mid_after_ready got %b exp 0", o_resp_ready); end
    idle();
    checks++; if (o_outstanding !== 4'd0) begin errors++; $display("FAIL mid_after_outstanding got %0d exp 0", o_outstanding); end
  endtask

  task automatic test_grant_encoding();
    do_reset();
    drive(4'b0000, 1'b1, 1'b0, 32'h0, 4'b0000);
    idle();
    checks++; if (o_outstanding !== 4'd0) begin errors++; $display("FAIL zero_grant_outstanding got %0d exp 0", o_outstanding); end
    checks++; if (o_err !== ERR_EN) begin errors++; $display("FAIL zero_grant_err got %b exp %b", o_err, ERR_EN); end
    do_reset();
    drive(4'b0110, 1'b1, 1'b0, 32'h0, 4'b0000);
    checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL multi_grant_err_early got %b exp 0", o_err); end
    exp_q.push_back(1);
    idle();
    checks++; if (o_err !== ERR_EN) begin errors++; $display("FAIL multi_grant_err got %b exp %b", o_err, ERR_EN); end
    checks++; if (o_outstanding !== 4'd1) begin errors++; $display("FAIL multi_grant_outstanding got %0d exp 1", o_outstanding); end
    drive(4'b0000, 1'b0, 1'b1, 32'h77, 4'b1111);
    checks++; if (o_resp_valid !== (4'b0001 << exp_q[0])) begin errors++; $display("FAIL multi_grant_valid got %b exp 0010", o_resp_valid); end
    void'(exp_q.pop_front());
    idle();
  endtask

  initial begin
    test_reset();
    test_in_order();
    test_earliest();
    test_fill();
    test_backpressure();
    test_back_to_back();
    test_empty_resp();
    test_reset_mid();
    test_grant_encoding();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
